// File: rtl/stack_pkg.sv
// Shared stack definitions: operation encodings, sequencer states and the
// default stack bounds also used by the pipeline's push/pop address logic.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_PUSH16 = 2'b00,
        OP_POP16  = 2'b01,
        OP_PUSH32 = 2'b10,
        OP_POP32  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        RD_A,
        RD_B,
        CAP_B,
        CAP_A,
        FAULT
    } state_e;

    localparam logic [31:0] SP_RESET_DEFAULT = 32'h000F_FFFF;
    localparam logic [31:0] SP_LIMIT_DEFAULT = 32'h0000_0800;

endpackage

// File: rtl/stack_access_unit.sv
// Stack access sequencer: owns SP and breaks 16/32-bit push/pop requests into
// 16-bit data-memory accesses, stalling the pipeline through ready.
module stack_access_unit
    import stack_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEFAULT),
    parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [31:0]       push_data,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       pop_data,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    state_e            state, state_n;
    op_e               op_q, op_n;
    logic [15:0]       data_q, data_n;
    logic [15:0]       lo_q, lo_n;
    logic [31:0]       pop_q, pop_n;
    logic [ADDR_W-1:0] sp_n, addr_n;
    logic [15:0]       wdata_n;
    logic              we_n, re_n, done_n, err_n;
    logic              bound_fault;

    assign ready = (state == IDLE);

    // Read data arrives in the done cycle, so it is forwarded straight out
    // and registered for the hold period that follows.
    always_comb begin
        case (state)
            CAP_A:   pop_data = {16'h0000, mem_rdata};
            CAP_B:   pop_data = {mem_rdata, lo_q};
            default: pop_data = pop_q;
        endcase
    end

    always_comb begin
        case (op_e'(op))
            OP_PUSH16: bound_fault = (sp < SP_LIMIT);
            OP_PUSH32: bound_fault = ((sp - ONE) < SP_LIMIT);
            OP_POP16:  bound_fault = ((sp + ONE) > SP_RESET);
            OP_POP32:  bound_fault = ((sp + TWO) > SP_RESET);
            default:   bound_fault = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        op_n    = op_q;
        data_n  = data_q;
        lo_n    = lo_q;
        pop_n   = pop_q;
        sp_n    = sp;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        we_n    = 1'b0;
        re_n    = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    op_n   = op_e'(op);
                    data_n = push_data[15:0];
                    if (bound_fault) begin
                        state_n = FAULT;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                    end else begin
                        case (op_e'(op))
                            OP_PUSH16: begin
                                state_n = WR_A;
                                we_n    = 1'b1;
                                addr_n  = sp;
                                wdata_n = push_data[15:0];
                                done_n  = 1'b1;
                            end
                            OP_PUSH32: begin
                                state_n = WR_A;
                                we_n    = 1'b1;
                                addr_n  = sp;
                                wdata_n = push_data[31:16];
                            end
                            default: begin
                                state_n = RD_A;
                                re_n    = 1'b1;
                                addr_n  = sp + ONE;
                            end
                        endcase
                    end
                end
            end
            WR_A: begin
                if (op_q == OP_PUSH32) begin
                    state_n = WR_B;
                    we_n    = 1'b1;
                    addr_n  = sp - ONE;
                    wdata_n = data_q;
                    done_n  = 1'b1;
                end else begin
                    sp_n    = sp - ONE;
                    state_n = IDLE;
                end
            end
            WR_B: begin
                sp_n    = sp - TWO;
                state_n = IDLE;
            end
            RD_A: begin
                done_n = 1'b1;
                if (op_q == OP_POP32) begin
                    state_n = RD_B;
                    re_n    = 1'b1;
                    addr_n  = sp + TWO;
                    done_n  = 1'b0;
                end else begin
                    state_n = CAP_A;
                end
            end
            RD_B: begin
                lo_n    = mem_rdata;
                state_n = CAP_B;
                done_n  = 1'b1;
            end
            CAP_A: begin
                pop_n   = {16'h0000, mem_rdata};
                sp_n    = sp + ONE;
                state_n = IDLE;
            end
            CAP_B: begin
                pop_n   = {mem_rdata, lo_q};
                sp_n    = sp + TWO;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_PUSH16;
            data_q    <= '0;
            lo_q      <= '0;
            pop_q     <= '0;
            sp        <= SP_RESET;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            data_q    <= data_n;
            lo_q      <= lo_n;
            pop_q     <= pop_n;
            sp        <= sp_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_we    <= we_n;
            mem_re    <= re_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule

// File: doc/stack_access_unit.md
Name: stack_access_unit

Overview:
- Memory-side consumer of stack requests issued by the pipeline's push/pop address logic.
- Owns the architectural stack pointer (SP).
- Sequences the 16-bit data-memory accesses for 16-bit PUSH/POP and 32-bit PC push/pop (CALL/INT, RET/RTI).
- Returns popped data and stalls the pipeline via ready while a multi-cycle access is in flight.

Parameters:
- ADDR_W, 32, width of SP and memory address.
- SP_RESET, 32'h000F_FFFF, SP value after reset; also defines "stack empty".
- SP_LIMIT, 32'h0000_0800, lowest address a push may write; below it is overflow.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req  input  1  stack request valid; accepted only when ready=1
- op  input  2  operation: 00 PUSH16, 01 POP16, 10 PUSH32, 11 POP32
- push_data  input  32  push value, sampled at acceptance; PUSH16 uses [15:0]
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse when the operation completes
- err  output  1  one-cycle pulse coincident with done on overflow/underflow
- pop_data  output  32  popped value, valid from the done cycle until the next acceptance; POP16 zero-extends
- sp  output  ADDR_W  current SP
- mem_addr  output  ADDR_W  memory word address
- mem_we  output  1  write strobe
- mem_re  output  1  read strobe; mem_rdata is valid the following cycle
- mem_wdata  output  16  write data
- mem_rdata  input  16  read data

Behaviour:
- Reset values:
  - sp=SP_RESET, state IDLE, ready=1.
  - done, err, mem_we, mem_re = 0.
  - pop_data=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts immediately. No further strobes are issued and no done is produced.
- Acceptance:
  - req&&ready in cycle 0 latches op and push_data, and drives ready low from cycle 1.
  - req while ready=0 is ignored; there is no queueing.
- Memory layout:
  - Stack grows downward. Push is post-decrement; pop is pre-increment.
  - 32-bit values are stored high half at the higher address.
- States: IDLE, WR_A, WR_B, RD_A, RD_B, CAP_B, CAP_A, FAULT.
- PUSH16: IDLE->WR_A.
  - Cycle 1: mem_we=1, addr=SP, wdata=data[15:0], SP<=SP-1, done=1. Then ->IDLE.
- PUSH32: IDLE->WR_A->WR_B.
  - Cycle 1: write data[31:16] at SP.
  - Cycle 2: write data[15:0] at SP-1, SP<=SP-2, done=1. Then ->IDLE.
- POP16: IDLE->RD_A->CAP_A.
  - Cycle 1: mem_re=1, addr=SP+1.
  - Cycle 2: pop_data={16'h0,mem_rdata}, SP<=SP+1, done=1.
- POP32: IDLE->RD_A->RD_B->CAP_B.
  - Cycle 1: read SP+1 (low half).
  - Cycle 2: capture low half; mem_re addr=SP+2.
  - Cycle 3: capture high half, SP<=SP+2, done=1.
- Latency from acceptance to done: PUSH16 1, PUSH32 2, POP16 2, POP32 3. The next acceptance is possible in the cycle after done.
- Underflow:
  - Condition: POP16 with SP+1>SP_RESET, or POP32 with SP+2>SP_RESET.
  - Response: ->FAULT for one cycle; done=1, err=1, no memory strobes, SP and pop_data unchanged.
- Overflow:
  - Condition: PUSH16 with SP<SP_LIMIT, or PUSH32 with SP-1<SP_LIMIT.
  - Response: ->FAULT, same response as underflow.
- Boundary checks use ADDR_W-bit unsigned compares evaluated at acceptance, so there is no wrap-around.
- mem_we and mem_re are never both high. When neither is high, mem_addr and mem_wdata hold their last values.

Decomposition:
- Shared package stack_pkg:
  - op encodings: OP_PUSH16, OP_POP16, OP_PUSH32, OP_POP32.
  - state enum.
  - SP_RESET and SP_LIMIT defaults, shared with the push/pop address logic.
- No sub-module needed. The FSM plus SP register forms a single module.

Test Plan:
- Reset, then idle: sp=32'h000F_FFFF, ready=1, no strobes.
- PUSH16 with push_data=32'h0000_ABCD:
  - Cycle 1: mem_we=1, addr=0xFFFFF, wdata=0xABCD, done=1.
  - Afterwards: sp=0xFFFFE.
- PUSH32 of 32'h1234_5678, then POP32:
  - Writes 0x1234@0xFFFFF and 0x5678@0xFFFFE; sp=0xFFFFD.
  - POP32 reads 0xFFFFE then 0xFFFFF; pop_data=32'h1234_5678 on done (3 cycles after acceptance); sp=0xFFFFF.
- POP16 on an empty stack: done=1 and err=1 in cycle 1, no mem_re, sp stays 0xFFFFF.
- req held high during PUSH32: second request not accepted until ready returns; exactly one done per acceptance.
- rst asserted in RD_B of POP32: next cycle IDLE, sp=0xFFFFF, no done, no mem_re.
